input_debounce: RTL and testbench

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/sys_structs.sv | 13 +
 rtl/input_debounce_sync_chain.sv | 25 ++
 rtl/input_debounce.sv | 108 ++++++++++
 tb/tb_input_debounce.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sys_structs.sv
// rtl/sys_structs.sv - shared typedefs for pin-conditioning blocks
package sys_structs;

  // Debounce filter state: STABLE tracks the accepted level, QUALIFY counts a candidate change
  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } debounce_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/input_debounce_sync_chain.sv
// rtl/input_debounce_sync_chain.sv - multi-flop synchronizer for asynchronous pin inputs
module sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the raw pin through the chain every clock; the oldest sample is the synchronized value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= {STAGES{RESET_LEVEL}};
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - synchronizer plus counting debounce filter with glitch reporting
module input_debounce
  import sys_structs::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   COUNT_WIDTH = 8,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   async_rst,
  input  logic                   clk_en,
  input  logic                   debounce_en_i,
  input  logic [COUNT_WIDTH-1:0] threshold_i,
  input  logic                   async_i,
  output logic                   clean_o,
  output logic                   qualifying_o,
  output logic                   glitch_o
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic                   sync;
  debounce_state_e        state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   clean_d, glitch_d;
  logic [COUNT_WIDTH-1:0] eff_n;
  logic [COUNT_WIDTH:0]   cnt_inc;
  logic                   mismatch, accept, n_is_one;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (async_rst),
    .d   (async_i),
    .q   (sync)
  );

  // A zero threshold behaves as one; the increment is one bit wider so the compare never wraps
  assign eff_n    = (threshold_i == '0) ? CNT_ONE : threshold_i;
  assign n_is_one = (eff_n == CNT_ONE);
  assign mismatch = (sync != clean_o);
  assign cnt_inc  = {1'b0, cnt_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
  assign accept   = (cnt_inc >= {1'b0, eff_n});

  // State register: FSM, counter and all registered outputs
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q      <= STABLE;
      cnt_q        <= '0;
      clean_o      <= RESET_LEVEL;
      glitch_o     <= 1'b0;
      qualifying_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clean_o      <= clean_d;
      glitch_o     <= glitch_d;
      qualifying_o <= (state_d == QUALIFY);
    end
  end

  // Next-state logic: bypass forces STABLE, otherwise advance only on qualify ticks
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!debounce_en_i) begin
      state_d = STABLE;
      cnt_d   = '0;
    end else if (clk_en) begin
      if (state_q == STABLE) begin
        if (mismatch && !n_is_one) begin
          state_d = QUALIFY;
          cnt_d   = CNT_ONE;
        end
      end else if (mismatch) begin
        if (accept) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[COUNT_WIDTH-1:0];
        end
      end else begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    end
  end

  // Output logic: accepted level and the aborted-transition pulse
  always_comb begin
    clean_d  = clean_o;
    glitch_d = 1'b0;
    if (!debounce_en_i) begin
      clean_d = sync;
    end else if (clk_en) begin
      if (state_q == STABLE) begin
        if (mismatch && n_is_one) clean_d = sync;
      end else if (mismatch) begin
        if (accept) clean_d = sync;
      end else begin
        glitch_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_debounce.sv
// tb/tb_input_debounce.sv - randomized and directed bench for input_debounce against a run-length model
module tb_input_debounce;

  localparam int   S  = 3;
  localparam int   CW = 8;
  localparam logic RL = 1'b0;

  logic          clk = 1'b0;
  logic          async_rst;
  logic          clk_en;
  logic          debounce_en_i;
  logic [CW-1:0] threshold_i;
  logic          async_i;
  logic          clean_o;
  logic          qualifying_o;
  logic          glitch_o;

  input_debounce #(
    .SYNC_STAGES (S),
    .COUNT_WIDTH (CW),
    .RESET_LEVEL (RL)
  ) dut (
    .clk           (clk),
    .async_rst     (async_rst),
    .clk_en        (clk_en),
    .debounce_en_i (debounce_en_i),
    .threshold_i   (threshold_i),
    .async_i       (async_i),
    .clean_o       (clean_o),
    .qualifying_o  (qualifying_o),
    .glitch_o      (glitch_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: pin delay line, accepted level, length of the current mismatch run
  logic pin_q[$];
  logic clean_m;
  logic glitch_m;
  int   run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pin_q.delete();
    for (int i = 0; i < S; i++) pin_q.push_back(RL);
    clean_m  = RL;
    glitch_m = 1'b0;
    run      = 0;
  endtask

  task automatic model_edge();
    logic s;
    int   n;
    s = pin_q[0];
    pin_q.push_back(async_i);
    void'(pin_q.pop_front());
    glitch_m = 1'b0;
    if (!debounce_en_i) begin
      clean_m = s;
      run     = 0;
    end else if (clk_en) begin
      n = (threshold_i == 0) ? 1 : int'(threshold_i);
      if (s != clean_m) begin
        run++;
        if (run >= n) begin
          clean_m = s;
          run     = 0;
        end
      end else begin
        if (run > 0) glitch_m = 1'b1;
        run = 0;
      end
    end
  endtask

  task automatic step(input logic pin, input logic en, input logic ben, input logic [CW-1:0] thr);
    async_i       = pin;
    clk_en        = en;
    debounce_en_i = ben;
    threshold_i   = thr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("clean", 32'(clean_o), 32'(clean_m));
    chk("qualifying", 32'(qualifying_o), 32'(run > 0));
    chk("glitch", 32'(glitch_o), 32'(glitch_m));
  endtask

  task automatic pulse_reset();
    #2 async_rst = 1'b1;
    model_reset();
    #1;
    chk("rst_clean", 32'(clean_o), 32'(RL));
    chk("rst_qual", 32'(qualifying_o), 32'd0);
    chk("rst_glitch", 32'(glitch_o), 32'd0);
    @(negedge clk);
    async_rst = 1'b0;
  endtask

  initial begin
    int   lat, qual_cnt, gl_cnt, hi_cnt;
    logic hist[$];
    logic p;

    async_rst = 1'b1; clk_en = 1'b0; debounce_en_i = 1'b1; threshold_i = '0; async_i = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_clean", 32'(clean_o), 32'(RL));
    chk("reset_qual", 32'(qualifying_o), 32'd0);
    chk("reset_glitch", 32'(glitch_o), 32'd0);
    async_rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 8'd3);

    // N=3 rising edge: latency S+3 with two cycles in QUALIFY
    lat = -1; qual_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'd3);
      if (qualifying_o) qual_cnt++;
      if (clean_o && lat < 0) lat = i;
    end
    chk("n3_latency", 32'(lat), 32'(S + 3));
    chk("n3_qual_cycles", 32'(qual_cnt), 32'd2);

    // N=4 two-cycle bounce: aborted with a single glitch pulse
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 8'd1);
    gl_cnt = 0; hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step((i < 2) ? 1'b1 : 1'b0, 1'b1, 1'b1, 8'd4);
      if (glitch_o) gl_cnt++;
      if (clean_o) hi_cnt++;
    end
    chk("n4_glitches", 32'(gl_cnt), 32'd1);
    chk("n4_clean_high", 32'(hi_cnt), 32'd0);
    chk("n4_qual_end", 32'(qualifying_o), 32'd0);

    // N=2 with clk_en every 4th clk
    for (int i = 0; i < 40; i++) step(1'b1, (i % 4) == 0, 1'b1, 8'd2);

    // N=200, threshold lowered to 5 once the count reaches 10
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 300 && run != 10; i++) step(1'b1, 1'b1, 1'b1, 8'd200);
    chk("n200_qualifying", 32'(qualifying_o), 32'd1);
    chk("n200_clean_low", 32'(clean_o), 32'd0);
    step(1'b1, 1'b1, 1'b1, 8'd5);
    chk("thr_live_accept", 32'(clean_o), 32'd1);

    // Bypass: clean follows the pin S+1 edges later, never a glitch
    gl_cnt = 0; p = 1'b0;
    for (int i = 0; i < 24; i++) begin
      p = ~p;
      hist.push_back(p);
      step(p, 1'b1, 1'b0, 8'd9);
      if (glitch_o) gl_cnt++;
      if (i >= S + 1) chk("bypass_follow", 32'(clean_o), 32'(hist[i - S]));
    end
    chk("bypass_glitches", 32'(gl_cnt), 32'd0);

    // Reset mid-QUALIFY (N=8, cnt=5), then a fresh full qualification
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 40 && run != 5; i++) step(1'b1, 1'b1, 1'b1, 8'd8);
    chk("n8_qualifying", 32'(qualifying_o), 32'd1);
    pulse_reset();
    lat = -1; gl_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'd8);
      if (glitch_o) gl_cnt++;
      if (clean_o && lat < 0) lat = i;
    end
    chk("post_rst_latency", 32'(lat), 32'(S + 8));
    chk("post_rst_glitches", 32'(gl_cnt), 32'd0);

    // Random soak against the run-length model
    begin
      logic          pin, en, ben;
      logic [CW-1:0] thr;
      pin = 1'b1; ben = 1'b1; thr = 8'd3;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 3) == 0) pin = ~pin;
        if ($urandom_range(0, 49) == 0) thr = CW'($urandom_range(0, 6));
        if ($urandom_range(0, 99) == 0) ben = ~ben;
        en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 999) == 0) pulse_reset();
        step(pin, en, ben, thr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
